// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between instruction fetch and data access
//
// Purpose: grants one memory access per cycle to either the fetch port (IF) or the
// load/store port (D), drives the shared synchronous memory, and routes read data back
// to the requesting port MEM_LAT cycles later. Data has priority by default; a fetch
// that is denied STARVE_MAX consecutive cycles gets priority until it is granted.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   if_req/if_addr           fetch request, held until if_gnt
//   if_gnt/if_rvalid/if_rdata fetch grant, read valid, read data
//   d_req/d_we/d_addr/d_wdata data request (d_we==0 is a load), held until d_gnt
//   d_gnt/d_rvalid/d_rdata   data grant, load valid, load data
//   mem_en/mem_we/mem_addr/mem_din/mem_dout  shared memory interface
//   stall                    some request is pending without a grant this cycle
module mem_port_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic [3:0]        d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              stall
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic {D_PRI, I_PRI} state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_IF, TAG_D} tag_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] starve_cnt, starve_nxt;
    tag_t             tag_pipe [MEM_LAT];
    tag_t             tag_in;

    // Grants are gated by rst so every output is quiet while reset is held,
    // even though the requests themselves may still be asserted.
    always_comb begin
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        state_nxt  = state;
        starve_nxt = starve_cnt;
        tag_in     = TAG_NONE;

        if (rst) begin
            if (state == I_PRI) begin
                if_gnt = if_req;
                d_gnt  = d_req & ~if_req;
            end else begin
                d_gnt  = d_req;
                if_gnt = if_req & ~d_req;
            end
        end

        if (if_gnt) begin
            starve_nxt = '0;
        end else if (if_req && starve_cnt != CNT_MAX) begin
            starve_nxt = starve_cnt + CNT_W'(1);
        end

        // Switching on the updated count lets the fetch win on the very cycle
        // after its STARVE_MAX-th denial.
        case (state)
            D_PRI: if (starve_nxt == CNT_MAX) state_nxt = I_PRI;
            I_PRI: if (if_gnt) state_nxt = D_PRI;
            default: state_nxt = D_PRI;
        endcase

        if (if_gnt) begin
            tag_in = TAG_IF;
        end else if (d_gnt && d_we == 4'b0000) begin
            tag_in = TAG_D;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= D_PRI;
            starve_cnt <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                tag_pipe[i] <= TAG_NONE;
            end
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            tag_pipe[0] <= tag_in;
            for (int i = 1; i < MEM_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign mem_en   = if_gnt | d_gnt;
    assign mem_we   = d_gnt ? d_we : 4'b0000;
    assign mem_addr = d_gnt ? d_addr : (if_gnt ? if_addr : '0);
    assign mem_din  = d_gnt ? d_wdata : '0;

    assign stall = rst & ((if_req & ~if_gnt) | (d_req & ~d_gnt));

    // The tag leaving the last stage marks which port owns the current mem_dout.
    assign if_rvalid = (tag_pipe[MEM_LAT-1] == TAG_IF);
    assign d_rvalid  = (tag_pipe[MEM_LAT-1] == TAG_D);
    assign if_rdata  = rst ? mem_dout : '0;
    assign d_rdata   = rst ? mem_dout : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard testbench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int AW   = 14;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic [3:0]    d_we = '0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;
    logic          stall;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .stall(stall)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural BRAM: reads return data LAT cycles after the access.
    logic [DW-1:0] bram    [0:1023];
    logic [DW-1:0] ref_mem [0:1023];
    logic [DW-1:0] rd_pipe [LAT];
    assign mem_dout = rd_pipe[LAT-1];

    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= $urandom;
        if (mem_en) begin
            if (mem_we == 4'b0000) begin
                rd_pipe[0] <= bram[mem_addr[9:0]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (mem_we[b]) bram[mem_addr[9:0]][8*b +: 8] <= mem_din[8*b +: 8];
            end
        end
    end

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;
    exp_t if_q[$];
    exp_t d_q[$];
    exp_t if_e, d_e;

    // Reference model state: whether fetch currently has priority, and how many
    // consecutive cycles the fetch has been refused.
    bit       m_ipri = 0;
    int       m_wait = 0;
    bit       last_ig = 0;
    logic [5:0] dhist = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        bit ed, ei;
        ed = d_req && !(m_ipri && if_req);
        ei = if_req && !ed;
        check("if_gnt", if_gnt, ei);
        check("d_gnt", d_gnt, ed);
        check("stall", stall, (if_req && !ei) || (d_req && !ed));
        check("mem_en", mem_en, ei || ed);
        check("mem_addr", mem_addr, ed ? d_addr : (ei ? if_addr : '0));
        check("mem_we", mem_we, ed ? d_we : 4'b0000);
        if (!ei) check("mem_din", mem_din, ed ? d_wdata : '0);
        dhist = {dhist[4:0], d_gnt};

        if (ei) if_q.push_back('{cyc + LAT, ref_mem[if_addr[9:0]]});
        if (ed) begin
            if (d_we == 4'b0000) begin
                d_q.push_back('{cyc + LAT, ref_mem[d_addr[9:0]]});
            end else begin
                for (int b = 0; b < 4; b++)
                    if (d_we[b]) ref_mem[d_addr[9:0]][8*b +: 8] = d_wdata[8*b +: 8];
            end
        end

        if (ei) begin
            m_wait = 0;
            m_ipri = 0;
        end else if (if_req) begin
            if (m_wait < SMAX) m_wait++;
            if (m_wait == SMAX) m_ipri = 1;
        end
        last_ig = ei;
    endtask

    task automatic cyc_do(input bit ir, input logic [AW-1:0] ia, input bit dr,
                          input logic [3:0] we, input logic [AW-1:0] da, input logic [DW-1:0] wd);
        if_req = ir; if_addr = ia; d_req = dr; d_we = we; d_addr = da; d_wdata = wd;
        @(negedge clk);
        step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc_do(0, '0, 0, 4'b0000, '0, '0);
    endtask

    task automatic apply_reset(input bit hold_if);
        rst_n = 1'b0;
        if_req = hold_if; if_addr = 14'h7; d_req = 1'b0; d_we = '0;
        if_q.delete(); d_q.delete();
        m_ipri = 0; m_wait = 0; last_ig = 0;
        @(negedge clk);
        check("reset_outputs",
              {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_din, stall}, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: every rvalid must match the oldest expected read of that port,
    // arriving exactly on its due cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (if_rvalid) begin
                if (if_q.size() == 0) begin
                    check("if_rvalid_unexpected", 1, 0);
                end else begin
                    if_e = if_q.pop_front();
                    check("if_rvalid_cycle", cyc, if_e.due);
                    check("if_rdata", if_rdata, if_e.data);
                end
            end else if (if_q.size() > 0 && if_q[0].due <= cyc) begin
                check("if_rvalid_missing", 0, 1);
                void'(if_q.pop_front());
            end
            if (d_rvalid) begin
                if (d_q.size() == 0) begin
                    check("d_rvalid_unexpected", 1, 0);
                end else begin
                    d_e = d_q.pop_front();
                    check("d_rvalid_cycle", cyc, d_e.due);
                    check("d_rdata", d_rdata, d_e.data);
                end
            end else if (d_q.size() > 0 && d_q[0].due <= cyc) begin
                check("d_rvalid_missing", 0, 1);
                void'(d_q.pop_front());
            end
        end
    end

    bit            pi, pd;
    logic [AW-1:0] ia, da;
    logic [3:0]    we;
    logic [DW-1:0] wd;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            bram[i] = $urandom;
            ref_mem[i] = bram[i];
        end
        for (int i = 0; i < LAT; i++) rd_pipe[i] = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset with fetch pending, then fetch granted on the release cycle.
        apply_reset(1);
        cyc_do(1, 14'h7, 0, 4'b0000, '0, '0);
        idle(3);

        // Contention: data wins, fetch follows.
        cyc_do(1, 14'h9, 1, 4'b0000, 14'h5, '0);
        cyc_do(1, 14'h9, 0, 4'b0000, '0, '0);
        idle(3);

        // Starvation: DDDD I D.
        apply_reset(0);
        for (int i = 0; i < 6; i++) cyc_do(1, 14'h3, 1, 4'b0000, 14'h4, '0);
        check("starve_pattern", dhist, 6'b111101);
        idle(3);

        // Store then read back.
        cyc_do(0, '0, 1, 4'b0011, 14'h10, 32'hDEADBEEF);
        cyc_do(0, '0, 1, 4'b0000, 14'h10, '0);
        idle(3);

        // Back-to-back IF then D reads.
        cyc_do(1, 14'd20, 0, 4'b0000, '0, '0);
        cyc_do(0, '0, 1, 4'b0000, 14'd21, '0);
        idle(3);

        // Reset between grant and rvalid: the read must vanish.
        cyc_do(1, 14'd22, 0, 4'b0000, '0, '0);
        apply_reset(0);
        for (int i = 0; i < 4; i++) begin
            cyc_do(0, '0, 0, 4'b0000, '0, '0);
            check("no_rvalid_after_reset", {if_rvalid, d_rvalid}, 2'b00);
        end

        // Randomised traffic: requests held until granted, occasionally dropped.
        pi = 0; pd = 0;
        for (int n = 0; n < 400; n++) begin
            if (!pi || last_ig) begin
                pi = ($urandom_range(0, 9) < 6);
                ia = 14'($urandom_range(0, 31));
            end else if ($urandom_range(0, 19) == 0) begin
                pi = 0;
            end
            if (!pd || d_gnt) begin
                pd = ($urandom_range(0, 9) < 6);
                da = 14'($urandom_range(0, 31));
                we = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
                wd = $urandom;
            end else if ($urandom_range(0, 19) == 0) begin
                pd = 0;
            end
            cyc_do(pi, ia, pd, we, da, wd);
        end
        idle(LAT + 2);
        check("queues_drained", if_q.size() + d_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
